// File: rtl/i2c_reg_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
package i2c_reg_seq_pkg;

    localparam int unsigned ADDR_W             = 7;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned ERR_W              = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
    localparam int unsigned DEF_TW             = 20;

    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_NACK    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_WA,
        ST_DATA_REG,
        ST_DATA_VAL,
        ST_CMD_RD,
        ST_RD_DATA,
        ST_WAIT_IDLE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              read;
        logic [ADDR_W-1:0] dev_addr;
        logic [BYTE_W-1:0] reg_addr;
        logic [BYTE_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/i2c_reg_seq_timeout.sv
// Per-state watchdog: clears on request, saturates at the terminal count.
module i2c_reg_seq_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TW             = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc_c
);

    localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (cnt_q != TERMINAL) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign tc_c = (cnt_q == TERMINAL);

endmodule

// File: rtl/i2c_reg_seq.sv
// Expands one host register read/write into i2c_master command/data traffic
// and returns a single response carrying read data and status.
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TW             = DEF_TW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic [ADDR_W-1:0] req_dev_addr,
    input  logic [BYTE_W-1:0] req_reg_addr,
    input  logic [BYTE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BYTE_W-1:0] rsp_rdata,
    output logic [ERR_W-1:0]  rsp_error,
    output logic [ADDR_W-1:0] m_cmd_address,
    output logic              m_cmd_start,
    output logic              m_cmd_read,
    output logic              m_cmd_write_multiple,
    output logic              m_cmd_stop,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [BYTE_W-1:0] m_data_tdata,
    output logic              m_data_tvalid,
    output logic              m_data_tlast,
    input  logic              m_data_tready,
    input  logic [BYTE_W-1:0] s_data_tdata,
    input  logic              s_data_tvalid,
    input  logic              s_data_tlast,
    output logic              s_data_tready,
    input  logic              missed_ack,
    input  logic              busy
);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic              nack_q, nack_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              tmo_tc_c;
    logic              unused_tlast;

    logic              req_ready_d, rsp_valid_d, s_data_tready_d;
    logic [BYTE_W-1:0] rsp_rdata_d, m_data_tdata_d;
    logic [ERR_W-1:0]  rsp_error_d;
    logic [ADDR_W-1:0] m_cmd_address_d;
    logic              m_cmd_valid_d, m_cmd_start_d, m_cmd_read_d;
    logic              m_cmd_write_multiple_d, m_cmd_stop_d;
    logic              m_data_tvalid_d, m_data_tlast_d;

    // Only the first read byte matters, so its tlast carries no information.
    assign unused_tlast = s_data_tlast;

    i2c_reg_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clear(state_d != state_q),
        .tc_c (tmo_tc_c)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        nack_d      = nack_q;
        rdata_d     = rdata_q;
        rsp_error_d = rsp_error;
        rsp_rdata_d = rsp_rdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = ST_CMD_WA;
                    req_d   = '{read: req_read, dev_addr: req_dev_addr,
                                reg_addr: req_reg_addr, wdata: req_wdata};
                    nack_d  = 1'b0;
                    rdata_d = '0;
                end
            end
            ST_CMD_WA:    if (m_cmd_valid && m_cmd_ready) state_d = ST_DATA_REG;
            ST_DATA_REG:  if (m_data_tvalid && m_data_tready)
                              state_d = req_q.read ? ST_CMD_RD : ST_DATA_VAL;
            ST_DATA_VAL:  if (m_data_tvalid && m_data_tready) state_d = ST_WAIT_IDLE;
            ST_CMD_RD:    if (m_cmd_valid && m_cmd_ready) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (s_data_tvalid && s_data_tready) begin
                    rdata_d = s_data_tdata;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: if (!busy) state_d = ST_RESP;
            ST_RESP:      if (rsp_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // Abort paths override the normal flow; timeout wins over nack for the target state.
        if (state_q != ST_IDLE && state_q != ST_RESP) begin
            if (missed_ack) begin
                nack_d  = 1'b1;
                state_d = ST_WAIT_IDLE;
            end
            if (tmo_tc_c) state_d = ST_RESP;
        end

        // Response payload is frozen on RESP entry; only a clean WAIT_IDLE exit is OK.
        if (state_d == ST_RESP && state_q != ST_RESP) begin
            if (nack_d)                                  rsp_error_d = ERR_NACK;
            else if (state_q == ST_WAIT_IDLE && !busy)   rsp_error_d = ERR_OK;
            else                                         rsp_error_d = ERR_TIMEOUT;
            rsp_rdata_d = (rsp_error_d == ERR_OK && req_d.read) ? rdata_d : '0;
        end

        req_ready_d            = (state_d == ST_IDLE);
        rsp_valid_d            = (state_d == ST_RESP);
        s_data_tready_d        = (state_d == ST_RD_DATA);
        m_cmd_valid_d          = (state_d == ST_CMD_WA) || (state_d == ST_CMD_RD);
        m_cmd_address_d        = m_cmd_valid_d ? req_d.dev_addr : '0;
        m_cmd_start_d          = m_cmd_valid_d;
        m_cmd_read_d           = (state_d == ST_CMD_RD);
        m_cmd_write_multiple_d = (state_d == ST_CMD_WA);
        m_cmd_stop_d           = (state_d == ST_CMD_RD) || ((state_d == ST_CMD_WA) && !req_d.read);
        m_data_tvalid_d        = (state_d == ST_DATA_REG) || (state_d == ST_DATA_VAL);
        m_data_tdata_d         = (state_d == ST_DATA_REG) ? req_d.reg_addr :
                                 (state_d == ST_DATA_VAL) ? req_d.wdata : '0;
        m_data_tlast_d         = (state_d == ST_DATA_VAL) || ((state_d == ST_DATA_REG) && req_d.read);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= ST_IDLE;
            req_q                <= '0;
            nack_q               <= 1'b0;
            rdata_q              <= '0;
            req_ready            <= 1'b1;
            rsp_valid            <= 1'b0;
            rsp_rdata            <= '0;
            rsp_error            <= '0;
            s_data_tready        <= 1'b0;
            m_cmd_valid          <= 1'b0;
            m_cmd_address        <= '0;
            m_cmd_start          <= 1'b0;
            m_cmd_read           <= 1'b0;
            m_cmd_write_multiple <= 1'b0;
            m_cmd_stop           <= 1'b0;
            m_data_tvalid        <= 1'b0;
            m_data_tdata         <= '0;
            m_data_tlast         <= 1'b0;
        end else begin
            state_q              <= state_d;
            req_q                <= req_d;
            nack_q               <= nack_d;
            rdata_q              <= rdata_d;
            req_ready            <= req_ready_d;
            rsp_valid            <= rsp_valid_d;
            rsp_rdata            <= rsp_rdata_d;
            rsp_error            <= rsp_error_d;
            s_data_tready        <= s_data_tready_d;
            m_cmd_valid          <= m_cmd_valid_d;
            m_cmd_address        <= m_cmd_address_d;
            m_cmd_start          <= m_cmd_start_d;
            m_cmd_read           <= m_cmd_read_d;
            m_cmd_write_multiple <= m_cmd_write_multiple_d;
            m_cmd_stop           <= m_cmd_stop_d;
            m_data_tvalid        <= m_data_tvalid_d;
            m_data_tdata         <= m_data_tdata_d;
            m_data_tlast         <= m_data_tlast_d;
        end
    end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
Register-access sequencer that sits directly upstream of i2c_master and drives its command and data AXI-stream ports. It accepts one host request per transaction: device address, 8-bit register address, read/write, and write data. It expands the request into the i2c_master command/data sequence, collects read data, and returns one response with status (OK / NACK / TIMEOUT).

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles spent in any single non-IDLE, non-RESP state before aborting
TW, 20, width of timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  host request valid
req_ready  out  1  high only in IDLE
req_read  in  1  1 = register read, 0 = register write
req_dev_addr  in  7  I2C 7-bit device address
req_reg_addr  in  8  register address byte
req_wdata  in  8  write data byte
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  host accepts response
rsp_rdata  out  8  read data; 0 for writes and errors
rsp_error  out  2  00 OK, 01 NACK, 10 TIMEOUT
m_cmd_address  out  7  to i2c_master s_axis_cmd_address
m_cmd_start, m_cmd_read, m_cmd_write_multiple, m_cmd_stop  out  1 each  command flags
m_cmd_valid  out  1 / m_cmd_ready  in  1  command handshake
m_data_tdata  out  8 / m_data_tvalid  out  1 / m_data_tlast  out  1 / m_data_tready  in  1  write-data stream to master
s_data_tdata  in  8 / s_data_tvalid  in  1 / s_data_tlast  in  1 / s_data_tready  out  1  read-data stream from master
missed_ack  in  1  i2c_master NACK pulse
busy  in  1  i2c_master busy

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. State is IDLE.
- All outputs are registered. A request accepted on cycle N (req_valid & req_ready) asserts m_cmd_valid on cycle N+1. Request fields are latched at acceptance.
- Every valid output is held with stable payload until its handshake completes. m_cmd_write is not a port; the master's single-write command is unused.
- States and transitions:
  - IDLE -> CMD_WA on request.
  - CMD_WA: cmd = {addr, start=1, write_multiple=1, stop=!read}. On handshake -> DATA_REG.
  - DATA_REG: tdata = reg_addr, tlast = read. On handshake -> read ? CMD_RD : DATA_VAL.
  - DATA_VAL: tdata = wdata, tlast = 1. On handshake -> WAIT_IDLE.
  - CMD_RD: cmd = {addr, start=1, read=1, stop=1} (repeated start). On handshake -> RD_DATA.
  - RD_DATA: s_data_tready = 1. On beat, latch rdata -> WAIT_IDLE. A beat with tlast = 0 is accepted anyway, and only the first byte is kept.
  - WAIT_IDLE: wait for busy == 0 -> RESP.
  - RESP: rsp_valid = 1. On rsp_ready -> IDLE, rsp_valid cleared, req_ready = 1 on the next cycle.
- missed_ack: sets a sticky nack flag in any non-IDLE state. All pending cmd/data valids drop the next cycle, and the FSM goes to WAIT_IDLE. The response then carries error 01 and rdata 0.
- s_data_tready is 0 outside RD_DATA. A stray beat there is left unconsumed.
- Timeout:
  - The counter clears on every state change and counts otherwise.
  - At TIMEOUT_CYCLES-1 in any state other than IDLE or RESP: all valids drop and the FSM goes to RESP with error 10, unless nack is already set (NACK has precedence).
- A missed_ack in the same cycle as a handshake: the handshake completes, then the abort path is taken.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. An i2c_master transfer left in flight is its own concern.
- rsp_rdata and rsp_error hold their value while rsp_valid is high.

Decomposition:
- Shared header i2c_defs.vh: state encodings, error codes (I2C_ERR_OK/NACK/TIMEOUT), default TIMEOUT_CYCLES.
- One sub-module is natural: i2c_seq_timeout (loadable clear, terminal-count pulse, TW-bit counter).
- Everything else stays in i2c_reg_seq (about 200 lines).

Test Plan:
- Write, ACKing slave model (i2c_master + open-drain bus): dev 0x50, reg 0x12, wdata 0xA5 -> bus shows S, 0xA0, 0x12, 0xA5, P; rsp_error = 00, rsp_rdata = 0x00.
- Read, slave returns 0x3C: dev 0x50, reg 0x07 -> bus shows S, 0xA0, 0x07, Sr, 0xA1, 0x3C, NACK, P; rsp_rdata = 0x3C, rsp_error = 00.
- No slave present (address NACK) -> missed_ack seen, m_cmd_valid/m_data_tvalid drop, rsp_error = 01 once busy falls.
- TIMEOUT_CYCLES = 16, m_cmd_ready tied 0 -> rsp_valid rises within 18 cycles of acceptance, rsp_error = 10.
- rsp_ready held 0 for 50 cycles -> rsp_valid and payload stable and req_ready = 0 throughout; next request is accepted only after the rsp handshake.
- rst pulsed during DATA_REG -> all outputs at reset values the same cycle, req_ready = 1; the next request completes normally.
